// File: rtl/rv_alu2_pkg.sv
// Shared types for the second execute stage: operand/result buses, ALU selectors,
// divider states and the branch/M-extension funct3 encodings.
package rv_alu2_pkg;

   typedef enum logic [2:0] {
      RES_ARITH  = 3'd0,
      RES_LOGIC  = 3'd1,
      RES_SHIFT  = 3'd2,
      RES_SLT    = 3'd3,
      RES_MULDIV = 3'd4
   } alu_res_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // alu_ctrl is interpreted per alu_res group
   localparam logic [1:0] CTRL_ADD  = 2'd0, CTRL_SUB  = 2'd1;
   localparam logic [1:0] CTRL_AND  = 2'd0, CTRL_OR   = 2'd1, CTRL_XOR = 2'd2;
   localparam logic [1:0] CTRL_SLL  = 2'd0, CTRL_SRL  = 2'd1, CTRL_SRA = 2'd2;
   localparam logic [1:0] CTRL_SLT  = 2'd0, CTRL_SLTU = 2'd1;

   localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE  = 3'b001, F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
   localparam logic [2:0] F3_MUL  = 3'b000, F3_MULH = 3'b001, F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU = 3'b011, F3_DIV = 3'b100, F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110, F3_REMU = 3'b111;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      alu_res_t    alu_res;
      logic [1:0]  alu_ctrl;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic        reg_write;
      logic        store;
      logic        inst_jal_jalr;
      logic        inst_branch;
      logic [31:0] pc;
      logic [31:0] pc_target;
      logic [1:0]  res_src;
      logic [31:0] reg_data2;
      logic        compressed;
   } alu1_bus_t;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] pc_next;
      logic [31:0] pc_target;
      logic        pc_select;
      logic [4:0]  rd;
      logic        reg_write;
      logic        store;
      logic [1:0]  res_src;
      logic [2:0]  funct3;
      logic [31:0] reg_data2;
   } alu2_bus_t;

   function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               taken;
      sa    = a;
      sb    = b;
      taken = 1'b0;
      case (f3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = (sa < sb);
         F3_BGE:  taken = (sa >= sb);
         F3_BLTU: taken = (a < b);
         F3_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/rv_alu2_div.sv
// Iterative restoring divider (one quotient bit per cycle) with magnitude operands
// and sign fix-up on the way out; division by zero and signed overflow may finish early.
module rv_div_iter
   import rv_alu2_pkg::*;
#(
   parameter int DIV_EARLY_OUT = 1
)(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_flush,
   input  logic        i_hold,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   input  logic        i_signed,
   input  logic        i_rem_sel,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result
);

   div_state_t  r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_quot;
   logic [31:0] r_rem;
   logic [31:0] r_divisor;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_rem_sel;

   logic        w_go;
   logic        w_a_neg;
   logic        w_b_neg;
   logic        w_div_zero;
   logic        w_ovf;
   logic        w_early;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_shift;
   logic [32:0] w_trial;

   assign w_go       = i_start && !i_flush && (r_state == IDLE);
   assign w_a_neg    = i_signed && i_dividend[31];
   assign w_b_neg    = i_signed && i_divisor[31];
   assign w_abs_a    = w_a_neg ? (32'd0 - i_dividend) : i_dividend;
   assign w_abs_b    = w_b_neg ? (32'd0 - i_divisor) : i_divisor;
   assign w_div_zero = (i_divisor == 32'd0);
   assign w_ovf      = i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);
   assign w_early    = (DIV_EARLY_OUT != 0) && (w_div_zero || w_ovf);
   assign w_shift    = {r_rem, r_quot[31]};
   assign w_trial    = w_shift - {1'b0, r_divisor};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= 5'd0;
         r_quot    <= 32'd0;
         r_rem     <= 32'd0;
         r_divisor <= 32'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_rem_sel <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_cnt     <= 5'd0;
                  r_divisor <= w_abs_b;
                  r_neg_r   <= w_a_neg;
                  r_rem_sel <= i_rem_sel;
                  // a zero divisor keeps the all-ones quotient unsigned
                  r_neg_q   <= (w_a_neg ^ w_b_neg) && !w_div_zero && !w_early;
                  if (w_early) begin
                     r_quot  <= w_div_zero ? 32'hFFFF_FFFF : w_abs_a;
                     r_rem   <= w_div_zero ? w_abs_a : 32'd0;
                     r_state <= DONE;
                  end else begin
                     r_quot  <= w_abs_a;
                     r_rem   <= 32'd0;
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (i_flush) begin
                  r_state <= IDLE;
               end else begin
                  if (!w_trial[32]) begin
                     r_rem  <= w_trial[31:0];
                     r_quot <= {r_quot[30:0], 1'b1};
                  end else begin
                     r_rem  <= w_shift[31:0];
                     r_quot <= {r_quot[30:0], 1'b0};
                  end
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) r_state <= DONE;
               end
            end
            DONE: begin
               if (i_flush || !i_hold) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy   = w_go || (r_state == CALC);
   assign o_done   = (r_state == DONE);
   assign o_result = r_rem_sel ? (r_neg_r ? (32'd0 - r_rem) : r_rem)
                               : (r_neg_q ? (32'd0 - r_quot) : r_quot);

endmodule

// File: rtl/rv_alu2.sv
// Second execute stage: stage register, ALU, branch/jump resolution, link address,
// single-cycle multiplier and a stalling iterative divider.
module rv_alu2
   import rv_alu2_pkg::*;
#(
   parameter int MULDIV_EN     = 1,
   parameter int DIV_EARLY_OUT = 1
)(
   input  logic      i_clk,
   input  logic      i_reset_n,
   input  logic      i_flush,
   input  logic      i_stall,
   input  alu1_bus_t i_bus,
   output logic      o_stall_req,
   output alu2_bus_t o_bus
);

   alu1_bus_t          r_bus_p1;
   logic               r_valid_p1;

   logic               w_div_start;
   logic               w_div_busy;
   logic               w_div_done;
   logic [31:0]        w_div_result;
   logic [31:0]        w_mul_res;
   logic [31:0]        w_alu_res;
   logic [31:0]        w_pc_next;
   logic signed [31:0] w_op1;
   logic signed [31:0] w_op2;
   logic signed [63:0] w_ma;
   logic signed [63:0] w_mb;
   logic signed [63:0] w_prod;

   // Stage register p1: flush turns the held instruction into a bubble
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_bus_p1   <= '0;
         r_valid_p1 <= 1'b0;
      end else if (i_flush) begin
         r_valid_p1             <= 1'b0;
         r_bus_p1.reg_write     <= 1'b0;
         r_bus_p1.store         <= 1'b0;
         r_bus_p1.inst_branch   <= 1'b0;
         r_bus_p1.inst_jal_jalr <= 1'b0;
         if (r_bus_p1.alu_res == RES_MULDIV) r_bus_p1.alu_res <= RES_ARITH;
      end else if (!(i_stall || o_stall_req)) begin
         r_bus_p1   <= i_bus;
         r_valid_p1 <= 1'b1;
      end
   end

   assign w_div_start = (MULDIV_EN != 0) && r_valid_p1 &&
                        (r_bus_p1.alu_res == RES_MULDIV) && r_bus_p1.funct3[2];

   rv_div_iter #(.DIV_EARLY_OUT(DIV_EARLY_OUT)) u_div (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_start    (w_div_start),
      .i_flush    (i_flush),
      .i_hold     (i_stall),
      .i_dividend (r_bus_p1.op1),
      .i_divisor  (r_bus_p1.op2),
      .i_signed   (!r_bus_p1.funct3[0]),
      .i_rem_sel  (r_bus_p1.funct3[1]),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_result   (w_div_result)
   );

   assign o_stall_req = w_div_busy;
   assign w_op1       = r_bus_p1.op1;
   assign w_op2       = r_bus_p1.op2;
   assign w_pc_next   = r_bus_p1.pc + (r_bus_p1.compressed ? 32'd2 : 32'd4);

   // 33x33 signed product: MULHU zero-extends both, MULHSU only op2
   assign w_ma      = {{32{r_bus_p1.op1[31] && (r_bus_p1.funct3 != F3_MULHU)}}, r_bus_p1.op1};
   assign w_mb      = {{32{r_bus_p1.op2[31] && !r_bus_p1.funct3[1]}}, r_bus_p1.op2};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = (r_bus_p1.funct3 == F3_MUL) ? w_prod[31:0] : w_prod[63:32];

   always_comb begin
      w_alu_res = 32'd0;
      case (r_bus_p1.alu_res)
         RES_ARITH: w_alu_res = (r_bus_p1.alu_ctrl == CTRL_SUB) ? (r_bus_p1.op1 - r_bus_p1.op2)
                                                                : (r_bus_p1.op1 + r_bus_p1.op2);
         RES_LOGIC: begin
            case (r_bus_p1.alu_ctrl)
               CTRL_AND: w_alu_res = r_bus_p1.op1 & r_bus_p1.op2;
               CTRL_OR:  w_alu_res = r_bus_p1.op1 | r_bus_p1.op2;
               default:  w_alu_res = r_bus_p1.op1 ^ r_bus_p1.op2;
            endcase
         end
         RES_SHIFT: begin
            case (r_bus_p1.alu_ctrl)
               CTRL_SLL: w_alu_res = r_bus_p1.op1 << r_bus_p1.op2[4:0];
               CTRL_SRL: w_alu_res = r_bus_p1.op1 >> r_bus_p1.op2[4:0];
               default:  w_alu_res = w_op1 >>> r_bus_p1.op2[4:0];
            endcase
         end
         RES_SLT: w_alu_res = (r_bus_p1.alu_ctrl == CTRL_SLTU) ? {31'd0, r_bus_p1.op1 < r_bus_p1.op2}
                                                               : {31'd0, w_op1 < w_op2};
         RES_MULDIV: begin
            if (MULDIV_EN != 0) begin
               if (!r_bus_p1.funct3[2])  w_alu_res = w_mul_res;
               else if (w_div_done)      w_alu_res = w_div_result;
            end
         end
         default: w_alu_res = 32'd0;
      endcase
   end

   // Output bus: nothing architectural leaves while the divider holds the stage
   always_comb begin
      o_bus = '0;
      if (r_valid_p1) begin
         o_bus.result    = r_bus_p1.inst_jal_jalr ? w_pc_next : w_alu_res;
         o_bus.pc_next   = w_pc_next;
         o_bus.pc_target = {r_bus_p1.pc_target[31:1], 1'b0};
         o_bus.pc_select = !o_stall_req && (r_bus_p1.inst_jal_jalr ||
                           (r_bus_p1.inst_branch &&
                            branch_taken(r_bus_p1.funct3, r_bus_p1.op1, r_bus_p1.op2)));
         o_bus.rd        = r_bus_p1.rd;
         o_bus.reg_write = r_bus_p1.reg_write && !o_stall_req;
         o_bus.store     = r_bus_p1.store && !o_stall_req;
         o_bus.res_src   = r_bus_p1.res_src;
         o_bus.funct3    = r_bus_p1.funct3;
         o_bus.reg_data2 = r_bus_p1.reg_data2;
      end
   end

endmodule

// File: tb/tb_rv_alu2.sv
// Directed bench for rv_alu2: ALU, branches, links, multiplier, divider timing,
// flush, downstream stall in DONE and asynchronous reset mid-division.
module tb_rv_alu2;
   import rv_alu2_pkg::*;

   logic      clk;
   logic      rst_n;
   logic      flush;
   logic      stall;
   alu1_bus_t bus;
   logic      stall_req;
   alu2_bus_t obus;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      alu_res_t    r;
      logic [1:0]  c;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } avec_t;

   rv_alu2 #(.MULDIV_EN(1), .DIV_EARLY_OUT(1)) u_dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_flush     (flush),
      .i_stall     (stall),
      .i_bus       (bus),
      .o_stall_req (stall_req),
      .o_bus       (obus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic alu1_bus_t mk(input alu_res_t r, input logic [1:0] c, input logic [2:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
      alu1_bus_t t;
      t           = '0;
      t.alu_res   = r;
      t.alu_ctrl  = c;
      t.funct3    = f;
      t.op1       = a;
      t.op2       = b;
      t.rd        = 5'd3;
      t.reg_write = 1'b1;
      t.pc        = 32'h100;
      t.pc_target = 32'h200;
      t.reg_data2 = 32'hDEAD;
      return t;
   endfunction

   // Issues one divide and waits for the stall to drop; ncyc counts stalled cycles.
   task automatic run_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int ncyc, output logic [31:0] res, output logic leak);
      ncyc = 0;
      leak = 1'b0;
      bus  = mk(RES_MULDIV, 2'd0, f, a, b);
      @(negedge clk);
      bus  = '0;
      for (int i = 0; i < 100; i++) begin
         if (!stall_req) break;
         ncyc++;
         if (obus.reg_write !== 1'b0 || obus.pc_select !== 1'b0) leak = 1'b1;
         @(negedge clk);
      end
      res = obus.result;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus   = mk(RES_ARITH, CTRL_ADD, 3'd0, 32'd1, 32'd2);
      @(negedge clk);
      checks++;
      if (stall_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall actual=%b required=0", stall_req);
      end
      checks++;
      if (obus !== '0) begin
         failures++;
         $display("FAIL reset_bus actual=%h required=0", obus);
      end
      rst_n = 1'b1;
      bus   = '0;
      @(negedge clk);
   endtask

   task automatic test_alu();
      avec_t v [0:16];
      v = '{
         '{RES_ARITH,  CTRL_ADD,  3'd0,      32'h7FFF_FFFF, 32'h1,         32'h8000_0000},
         '{RES_ARITH,  CTRL_SUB,  3'd0,      32'h5,         32'h7,         32'hFFFF_FFFE},
         '{RES_LOGIC,  CTRL_AND,  3'd0,      32'hF0F0,      32'hFF00,      32'hF000},
         '{RES_LOGIC,  CTRL_OR,   3'd0,      32'hF0F0,      32'h0F0F,      32'hFFFF},
         '{RES_LOGIC,  CTRL_XOR,  3'd0,      32'hFFFF,      32'h0F0F,      32'hF0F0},
         '{RES_SHIFT,  CTRL_SLL,  3'd0,      32'h1,         32'd31,        32'h8000_0000},
         '{RES_SHIFT,  CTRL_SRL,  3'd0,      32'h8000_0000, 32'd4,         32'h0800_0000},
         '{RES_SHIFT,  CTRL_SRA,  3'd0,      32'h8000_0000, 32'd4,         32'hF800_0000},
         '{RES_SHIFT,  CTRL_SRA,  3'd0,      32'h8000_0000, 32'h23,        32'hF000_0000},
         '{RES_SLT,    CTRL_SLT,  3'd0,      32'hFFFF_FFFF, 32'h1,         32'h1},
         '{RES_SLT,    CTRL_SLTU, 3'd0,      32'hFFFF_FFFF, 32'h1,         32'h0},
         '{RES_MULDIV, 2'd0,      F3_MUL,    32'h3,         32'hFFFF_FFFE, 32'hFFFF_FFFA},
         '{RES_MULDIV, 2'd0,      F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0},
         '{RES_MULDIV, 2'd0,      F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
         '{RES_MULDIV, 2'd0,      F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
         '{RES_MULDIV, 2'd0,      F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{RES_ARITH,  CTRL_ADD,  3'd0,      32'hFFFF_FFFF, 32'h1,         32'h0}
      };
      for (int i = 0; i <= 16; i++) begin
         bus = mk(v[i].r, v[i].c, v[i].f, v[i].a, v[i].b);
         @(negedge clk);
         checks++;
         if (obus.result !== v[i].e || obus.reg_write !== 1'b1 || stall_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_vec%0d actual=%h/rw%b/st%b required=%h/rw1/st0",
                     i, obus.result, obus.reg_write, stall_req, v[i].e);
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0]  bf [0:5] = '{F3_BLT, F3_BLTU, F3_BEQ, F3_BNE, F3_BGE, F3_BGEU};
      logic [31:0] ba [0:5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd1, 32'd1};
      logic [31:0] bb [0:5] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic        be [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      alu1_bus_t   t;
      for (int i = 0; i < 6; i++) begin
         t             = mk(RES_ARITH, CTRL_SUB, bf[i], ba[i], bb[i]);
         t.inst_branch = 1'b1;
         t.reg_write   = 1'b0;
         t.pc_target   = 32'h201;
         bus           = t;
         @(negedge clk);
         checks++;
         if (obus.pc_select !== be[i] || obus.pc_target !== 32'h200) begin
            failures++;
            $display("FAIL branch_f3_%b actual=%b/%h required=%b/00000200",
                     bf[i], obus.pc_select, obus.pc_target, be[i]);
         end
      end
   endtask

   task automatic test_jal();
      alu1_bus_t t;
      for (int c = 0; c < 2; c++) begin
         t               = mk(RES_ARITH, CTRL_ADD, 3'd0, 32'h55, 32'h66);
         t.inst_jal_jalr = 1'b1;
         t.compressed    = (c == 1);
         bus             = t;
         @(negedge clk);
         checks++;
         if (obus.result !== ((c == 1) ? 32'h102 : 32'h104) || obus.pc_select !== 1'b1 ||
             obus.pc_next !== obus.result) begin
            failures++;
            $display("FAIL jal_c%0d actual=%h/%b required=%h/1",
                     c, obus.result, obus.pc_select, (c == 1) ? 32'h102 : 32'h104);
         end
      end
   endtask

   task automatic test_div();
      logic [2:0]  df [0:7] = '{F3_DIV, F3_REM, F3_DIV, F3_REMU, F3_DIVU, F3_REM, F3_REM, F3_DIV};
      logic [31:0] da [0:7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'h1234, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
      logic [31:0] db [0:7] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] de [0:7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      int          dn [0:7] = '{33, 33, 33, 33, 1, 1, 1, 1};
      int          n;
      logic [31:0] r;
      logic        leak;
      for (int i = 0; i < 8; i++) begin
         run_div(df[i], da[i], db[i], n, r, leak);
         checks++;
         if (n != dn[i] || r !== de[i] || leak !== 1'b0 || obus.reg_write !== 1'b1) begin
            failures++;
            $display("FAIL div_vec%0d actual=cyc%0d/%h/leak%b/rw%b required=cyc%0d/%h/leak0/rw1",
                     i, n, r, leak, obus.reg_write, dn[i], de[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_flush();
      bus = mk(RES_MULDIV, 2'd0, F3_DIV, 32'd100, 32'd7);
      @(negedge clk);
      bus = '0;
      repeat (11) @(negedge clk);
      checks++;
      if (stall_req !== 1'b1) begin
         failures++;
         $display("FAIL flush_pre_stall actual=%b required=1", stall_req);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (stall_req !== 1'b0 || obus.reg_write !== 1'b0) begin
         failures++;
         $display("FAIL flush_kill actual=st%b/rw%b required=st0/rw0", stall_req, obus.reg_write);
      end
      bus = mk(RES_ARITH, CTRL_ADD, 3'd0, 32'd3, 32'd4);
      @(negedge clk);
      checks++;
      if (obus.result !== 32'd7 || obus.reg_write !== 1'b1 || stall_req !== 1'b0) begin
         failures++;
         $display("FAIL flush_next_add actual=%h/rw%b required=00000007/rw1",
                  obus.result, obus.reg_write);
      end
   endtask

   task automatic test_stall_done();
      int n;
      bus = mk(RES_MULDIV, 2'd0, F3_DIV, 32'd100, 32'd7);
      @(negedge clk);
      bus = '0;
      n   = 0;
      while (stall_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      stall = 1'b1;
      bus   = mk(RES_ARITH, CTRL_ADD, 3'd0, 32'd1, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (obus.result !== 32'd14 || stall_req !== 1'b0 || obus.reg_write !== 1'b1) begin
            failures++;
            $display("FAIL stall_done_hold%0d actual=%h/st%b required=0000000e/st0",
                     i, obus.result, stall_req);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if (obus.result !== 32'd2 || stall_req !== 1'b0) begin
         failures++;
         $display("FAIL stall_done_release actual=%h/st%b required=00000002/st0",
                  obus.result, stall_req);
      end
   endtask

   task automatic test_async_reset();
      bus = mk(RES_MULDIV, 2'd0, F3_DIVU, 32'd1000, 32'd3);
      @(negedge clk);
      bus = '0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (stall_req !== 1'b0 || obus !== '0) begin
         failures++;
         $display("FAIL async_reset actual=st%b/%h required=st0/0", stall_req, obus);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus   = mk(RES_ARITH, CTRL_ADD, 3'd0, 32'd2, 32'd3);
      @(negedge clk);
      checks++;
      if (obus.result !== 32'd5 || stall_req !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_recover actual=%h/st%b required=00000005/st0",
                  obus.result, stall_req);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      stall = 1'b0;
      bus   = '0;
      test_reset();
      test_alu();
      test_branch();
      test_jal();
      test_div();
      test_flush();
      test_stall_done();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
